// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg: shared types, constants and the address decode helper
// for the blocking MMIO responder.
//   state_e          : responder FSM states (IDLE, LD_READ, LD_RESP)
//   ERR_DATA_DEFAULT : data returned for a load that misses the bank
//   ERR_CNT_W        : width of the saturating decode-error counter
//   decode_addr()    : hit flag and register index for a byte address
package mmio_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_READ = 2'd1,
    LD_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdeadbeef;
  localparam int unsigned ERR_CNT_W        = 8;
  // Widest index the decoder can produce (NUM_REGS <= 256).
  localparam int unsigned DEC_IDX_W        = 8;

  typedef struct packed {
    logic                 hit;
    logic [DEC_IDX_W-1:0] idx;
  } decode_t;

  // Offset wraps modulo 2^32, so addresses below the base decode as huge
  // offsets and miss.
  function automatic decode_t decode_addr(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned num_regs);
    logic [31:0] off;
    decode_t     d;
    off   = addr - base;
    d.hit = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < num_regs);
    d.idx = off[2 +: DEC_IDX_W];
    return d;
  endfunction

endpackage

// File: rtl/mmio_blocking_responder_if.sv
// mmio_blocking_responder_if: the core's blocking MMIO ports.
//   load  request : load_empty_in, load_addr_in  -> load_rden_out (pop)
//   load  result  : load_valid_out, load_result_out <- load_rdy_in
//   store request : store_empty_in, store_addr_in, store_value_in
//                   -> store_rden_out (pop)
// Modport master is the core side, slave is the responder side.
interface mmio_blocking_responder_if;
  logic        load_empty_in;
  logic [31:0] load_addr_in;
  logic        load_rden_out;
  logic        load_valid_out;
  logic [31:0] load_result_out;
  logic        load_rdy_in;
  logic        store_empty_in;
  logic [31:0] store_addr_in;
  logic [31:0] store_value_in;
  logic        store_rden_out;

  modport master (
    output load_empty_in, load_addr_in, load_rdy_in,
    output store_empty_in, store_addr_in, store_value_in,
    input  load_rden_out, load_valid_out, load_result_out, store_rden_out
  );

  modport slave (
    input  load_empty_in, load_addr_in, load_rdy_in,
    input  store_empty_in, store_addr_in, store_value_in,
    output load_rden_out, load_valid_out, load_result_out, store_rden_out
  );
endinterface

// File: rtl/mmio_responder_regbank.sv
// mmio_responder_regbank: NUM_REGS x 32-bit register bank.
//   clk, rst           : clock, synchronous active-high clear of all registers
//   we_i/waddr_i/wdata_i : single write port
//   re_i/raddr_i       : read request; rdata_o is registered (valid next cycle)
module mmio_responder_regbank #(
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= regs_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mmio_blocking_responder.sv
// mmio_blocking_responder: serves the core's blocking MMIO load/store ports
// from a register bank mapped at BASE_ADDR.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : load/store request FIFOs and load result handshake
//   error_count_out : saturating count of decode errors (misses)
// Optional (macro MMIO_RESPONDER_ACCESS_COUNT_EN):
//   load_count_out, store_count_out : wrapping counts of hit accesses
module mmio_blocking_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_blocking_responder_if.slave bus,
  output logic [ERR_CNT_W-1:0] error_count_out
`ifdef MMIO_RESPONDER_ACCESS_COUNT_EN
  ,
  output logic [15:0]          load_count_out,
  output logic [15:0]          store_count_out
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  state_e               state_q, state_d;
  logic                 ld_hit_q, ld_hit_d;
  logic                 valid_q;
  logic [31:0]          result_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 err_inc;
  logic                 store_rden, load_rden;
  logic                 bank_we;
  logic [31:0]          bank_rdata;
  decode_t              st_dec, ld_dec;
  logic                 unused_idx_bits;

  assign st_dec = decode_addr(bus.store_addr_in, BASE_ADDR, NUM_REGS);
  assign ld_dec = decode_addr(bus.load_addr_in, BASE_ADDR, NUM_REGS);
  // Index bits above IDX_W fall outside the bank for NUM_REGS < 256.
  assign unused_idx_bits = ^{st_dec.idx, ld_dec.idx};

  always_comb begin
    state_d    = state_q;
    ld_hit_d   = ld_hit_q;
    store_rden = 1'b0;
    load_rden  = 1'b0;
    bank_we    = 1'b0;
    err_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Store has priority so older stores drain before a younger load.
        if (!bus.store_empty_in) begin
          store_rden = 1'b1;
          bank_we    = st_dec.hit;
          err_inc    = !st_dec.hit;
        end else if (!bus.load_empty_in) begin
          load_rden = 1'b1;
          ld_hit_d  = ld_dec.hit;
          state_d   = LD_READ;
        end
      end
      LD_READ: begin
        err_inc = !ld_hit_q;
        state_d = LD_RESP;
      end
      LD_RESP: begin
        if (bus.load_rdy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pops are combinational, so mask them during reset to avoid losing a
    // request that the reset would otherwise discard.
    if (rst) begin
      store_rden = 1'b0;
      load_rden  = 1'b0;
      bank_we    = 1'b0;
      err_inc    = 1'b0;
    end
  end

  // Bank read is issued in the pop cycle so data is ready in LD_READ.
  mmio_responder_regbank #(.NUM_REGS(NUM_REGS)) u_regbank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bank_we),
    .waddr_i (IDX_W'(st_dec.idx)),
    .wdata_i (bus.store_value_in),
    .re_i    (load_rden),
    .raddr_i (IDX_W'(ld_dec.idx)),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ld_hit_q <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ld_hit_q <= ld_hit_d;
      if (state_q == LD_READ) begin
        result_q <= ld_hit_q ? bank_rdata : ERR_DATA;
        valid_q  <= 1'b1;
      end else if (state_q == LD_RESP && bus.load_rdy_in) begin
        valid_q  <= 1'b0;
      end
      if (err_inc && err_q != '1) err_q <= err_q + 1'b1;
    end
  end

  assign bus.store_rden_out  = store_rden;
  assign bus.load_rden_out   = load_rden;
  assign bus.load_valid_out  = valid_q;
  assign bus.load_result_out = result_q;
  assign error_count_out     = err_q;

`ifdef MMIO_RESPONDER_ACCESS_COUNT_EN
  logic [15:0] ld_cnt_q, st_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if (bank_we) st_cnt_q <= st_cnt_q + 1'b1;
      if (state_q == LD_RESP && valid_q && bus.load_rdy_in && ld_hit_q)
        ld_cnt_q <= ld_cnt_q + 1'b1;
    end
  end

  assign load_count_out  = ld_cnt_q;
  assign store_count_out = st_cnt_q;
`endif

endmodule

// File: tb/tb_mmio_blocking_responder.sv
module tb_mmio_blocking_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] error_count;
`ifdef MMIO_RESPONDER_ACCESS_COUNT_EN
  logic [15:0] load_count, store_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mmio_blocking_responder_if bus ();

  mmio_blocking_responder #(
    .BASE_ADDR (32'h1000_0000),
    .NUM_REGS  (16),
    .ERR_DATA  (32'hdeadbeef)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .error_count_out (error_count)
`ifdef MMIO_RESPONDER_ACCESS_COUNT_EN
    ,
    .load_count_out  (load_count),
    .store_count_out (store_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Store presented for one cycle: must pop in that cycle and not the next.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] val, input string tag);
    @(negedge clk);
    bus.store_addr_in  = addr;
    bus.store_value_in = val;
    bus.store_empty_in = 1'b0;
    #1 check({tag, " st_rden"}, 32'(bus.store_rden_out), 32'd1);
    @(negedge clk);
    bus.store_empty_in = 1'b1;
    #1 check({tag, " st_rden_off"}, 32'(bus.store_rden_out), 32'd0);
  endtask

  // Load with optional rdy stall; during the stall both FIFOs look non-empty.
  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp,
                         input int stall, input string tag);
    @(negedge clk);
    bus.load_addr_in  = addr;
    bus.load_empty_in = 1'b0;
    bus.load_rdy_in   = (stall == 0);
    #1 check({tag, " ld_rden"}, 32'(bus.load_rden_out), 32'd1);
    @(negedge clk);
    bus.load_empty_in = 1'b1;
    check({tag, " valid_t1"}, 32'(bus.load_valid_out), 32'd0);
    @(negedge clk);
    check({tag, " valid_t2"}, 32'(bus.load_valid_out), 32'd1);
    check({tag, " result"}, bus.load_result_out, exp);
    for (int i = 0; i < stall; i++) begin
      bus.store_empty_in = 1'b0;
      bus.load_empty_in  = 1'b0;
      #1;
      check({tag, " stall st_rden"}, 32'(bus.store_rden_out), 32'd0);
      check({tag, " stall ld_rden"}, 32'(bus.load_rden_out), 32'd0);
      @(negedge clk);
      check({tag, " stall valid"}, 32'(bus.load_valid_out), 32'd1);
      check({tag, " stall result"}, bus.load_result_out, exp);
    end
    bus.store_empty_in = 1'b1;
    bus.load_empty_in  = 1'b1;
    bus.load_rdy_in    = 1'b1;
    @(negedge clk);
    check({tag, " valid_done"}, 32'(bus.load_valid_out), 32'd0);
  endtask

  initial begin
    bus.load_empty_in  = 1'b1;
    bus.load_addr_in   = '0;
    bus.load_rdy_in    = 1'b1;
    bus.store_empty_in = 1'b1;
    bus.store_addr_in  = '0;
    bus.store_value_in = '0;

    // Reset values; a pending store must not pop while in reset.
    repeat (2) @(negedge clk);
    bus.store_empty_in = 1'b0;
    #1;
    check("rst st_rden", 32'(bus.store_rden_out), 32'd0);
    check("rst ld_rden", 32'(bus.load_rden_out), 32'd0);
    check("rst valid", 32'(bus.load_valid_out), 32'd0);
    check("rst result", bus.load_result_out, 32'd0);
    check("rst errcnt", 32'(error_count), 32'd0);
    bus.store_empty_in = 1'b1;
    rst = 1'b0;

    // Basic store then load back.
    do_store(32'h1000_0008, 32'h1122_3344, "st8");
    do_load(32'h1000_0008, 32'h1122_3344, 0, "ld8");
    check("errcnt basic", 32'(error_count), 32'd0);

    // Back-pressure on the result port.
    do_load(32'h1000_0008, 32'h1122_3344, 5, "ld8 stall");

    // Out-of-range and misaligned loads.
    do_load(32'h1000_0040, 32'hdeadbeef, 0, "ld oor");
    do_load(32'h1000_0002, 32'hdeadbeef, 0, "ld misal");
    check("errcnt 2", 32'(error_count), 32'd2);

    // Store miss is dropped.
    do_store(32'h0000_0000, 32'hffff_ffff, "st miss");
    check("errcnt 3", 32'(error_count), 32'd3);
    do_load(32'h1000_0008, 32'h1122_3344, 0, "ld8 after miss");
    do_load(32'h1000_0000, 32'h0000_0000, 0, "ld0 after miss");

    // Store and load presented together: store first, load sees the store.
    @(negedge clk);
    bus.store_addr_in  = 32'h1000_0000;
    bus.store_value_in = 32'd5;
    bus.store_empty_in = 1'b0;
    bus.load_addr_in   = 32'h1000_0000;
    bus.load_empty_in  = 1'b0;
    #1;
    check("both st_rden", 32'(bus.store_rden_out), 32'd1);
    check("both ld_rden", 32'(bus.load_rden_out), 32'd0);
    @(negedge clk);
    bus.store_empty_in = 1'b1;
    #1 check("both ld_rden2", 32'(bus.load_rden_out), 32'd1);
    @(negedge clk);
    bus.load_empty_in = 1'b1;
    check("both valid_t1", 32'(bus.load_valid_out), 32'd0);
    @(negedge clk);
    check("both valid_t2", 32'(bus.load_valid_out), 32'd1);
    check("both result", bus.load_result_out, 32'd5);
    @(negedge clk);
    check("both done", 32'(bus.load_valid_out), 32'd0);

    // Last register and an address just below the base.
    do_store(32'h1000_003c, 32'ha5a5_a5a5, "st15");
    do_load(32'h1000_003c, 32'ha5a5_a5a5, 0, "ld15");
    do_load(32'h0fff_fffc, 32'hdeadbeef, 0, "ld below");
    check("errcnt 4", 32'(error_count), 32'd4);
`ifdef MMIO_RESPONDER_ACCESS_COUNT_EN
    check("store_count", 32'(store_count), 32'd3);
    check("load_count", 32'(load_count), 32'd6);
`endif

    // Reset while the response is waiting in LD_RESP.
    @(negedge clk);
    bus.load_addr_in  = 32'h1000_0008;
    bus.load_empty_in = 1'b0;
    bus.load_rdy_in   = 1'b0;
    @(negedge clk);
    bus.load_empty_in = 1'b1;
    @(negedge clk);
    check("rst_mid valid before", 32'(bus.load_valid_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid valid", 32'(bus.load_valid_out), 32'd0);
    check("rst_mid result", bus.load_result_out, 32'd0);
    check("rst_mid errcnt", 32'(error_count), 32'd0);
    rst = 1'b0;
    bus.load_rdy_in = 1'b1;
    @(negedge clk);
    check("rst_mid no resp", 32'(bus.load_valid_out), 32'd0);
    do_load(32'h1000_0008, 32'h0, 0, "ld8 post rst");
    do_load(32'h1000_003c, 32'h0, 0, "ld15 post rst");
`ifdef MMIO_RESPONDER_ACCESS_COUNT_EN
    check("store_count post rst", 32'(store_count), 32'd0);
    check("load_count post rst", 32'(load_count), 32'd2);
`endif

    // Error counter saturation with back-to-back store misses.
    @(negedge clk);
    bus.store_addr_in  = 32'h0;
    bus.store_empty_in = 1'b0;
    repeat (254) @(negedge clk);
    check("errcnt fe", 32'(error_count), 32'h0fe);
    repeat (46) @(negedge clk);
    check("errcnt sat", 32'(error_count), 32'h0ff);
    bus.store_empty_in = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
